// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with a 2-entry skid buffer and a sideband tag.
// Define IMMGEN_RVC_EN to also expand RV16 compressed-instruction immediates.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_rvc
);

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_R   = 3'd5,
        FMT_UNK = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic [TAG_W-1:0] tag;
        logic             rvc;
    } entry_t;

    entry_t dec, out_q, skid_q;
    logic   skid_valid;
    logic   accept, consume;
    logic   [XLEN-1:0] imm_i;

    // NOTE: every field of dec gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec     = '0;
        dec.tag = in_tag;
        imm_i   = {{(XLEN-12){in_ir[31]}}, in_ir[31:20]};
        case (in_ir[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = {{(XLEN-12){in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = {{(XLEN-13){in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = {{(XLEN-32){in_ir[31]}}, in_ir[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = {{(XLEN-21){in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
            end
            7'b0110011: dec.fmt = FMT_R;
            default: begin
                dec.fmt = FMT_UNK;
                dec.imm = imm_i;
            end
        endcase
`ifdef IMMGEN_RVC_EN
        // Compressed word: the 16-bit decode overrides the 32-bit result above.
        if (in_ir[1:0] != 2'b11) begin
            dec.rvc = 1'b1;
            dec.fmt = FMT_UNK;
            dec.imm = '0;
            case ({in_ir[1:0], in_ir[15:13]})
                5'b01_000, 5'b01_010: begin
                    dec.fmt = FMT_I;
                    dec.imm = {{(XLEN-6){in_ir[12]}}, in_ir[12], in_ir[6:2]};
                end
                5'b01_011: begin
                    dec.fmt = FMT_U;
                    dec.imm = {{(XLEN-18){in_ir[12]}}, in_ir[12], in_ir[6:2], 12'b0};
                end
                5'b01_001, 5'b01_101: begin
                    dec.fmt = FMT_J;
                    dec.imm = {{(XLEN-12){in_ir[12]}}, in_ir[12], in_ir[8], in_ir[10:9], in_ir[6],
                               in_ir[7], in_ir[2], in_ir[11], in_ir[5:3], 1'b0};
                end
                5'b01_110, 5'b01_111: begin
                    dec.fmt = FMT_B;
                    dec.imm = {{(XLEN-9){in_ir[12]}}, in_ir[12], in_ir[6:5], in_ir[2],
                               in_ir[11:10], in_ir[4:3], 1'b0};
                end
                5'b00_010, 5'b00_110: begin
                    dec.fmt = in_ir[15] ? FMT_S : FMT_I;
                    dec.imm = {{(XLEN-7){1'b0}}, in_ir[5], in_ir[12:10], in_ir[6], 2'b0};
                end
                5'b10_010: begin
                    dec.fmt = FMT_I;
                    dec.imm = {{(XLEN-8){1'b0}}, in_ir[3:2], in_ir[12], in_ir[6:4], 2'b0};
                end
                5'b10_110: begin
                    dec.fmt = FMT_S;
                    dec.imm = {{(XLEN-8){1'b0}}, in_ir[8:7], in_ir[12:9], 2'b0};
                end
                default: ;
            endcase
        end
`endif
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the entry payloads are reset too, so out_* read zero after reset rather than X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume) begin
            // A full skid blocks accept, so draining it never races a new entry.
            if (skid_valid) begin
                out_q      <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q <= dec;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            if (out_valid) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end else begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end
        end
    end

    assign out_imm = out_q.imm;
    assign out_fmt = out_q.fmt;
    assign out_tag = out_q.tag;
    assign out_rvc = out_q.rvc;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, handshaked immediate generator for the decode stage. Decodes the instruction format from the opcode and produces the sign/zero-extended immediate, widened to XLEN. A 2-entry skid buffer lets fetch and execute stall independently. A sideband tag (PC) travels with each instruction. Optionally expands RV16 compressed-instruction immediates.

Parameters:
- XLEN, 32, immediate output width (32 or 64); sign-extension fills bits XLEN-1 down to the format's sign position.
- TAG_W, 32, width of the sideband tag carried alongside each instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept; equals NOT skid_valid.
- in_ir  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag (PC).
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 R, 7 UNK.
- out_tag  out  TAG_W  tag of the output entry.
- out_rvc  out  1  entry was compressed; tied to 0 when the feature is off.

Behaviour:
- Reset (rst=0, async): out_valid=0, skid_valid=0, in_ready=1, out_imm/out_fmt/out_tag/out_rvc=0. Reset mid-stall drops both entries immediately.
- Format decode on opcode in_ir[6:0]:
  - I: 0010011, 0000011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011; imm=0.
  - Any other opcode: fmt=7, imm=I-format value.
- Immediate layout:
  - I: sext(ir[31:20]).
  - S: sext({ir[31:25], ir[11:7]}).
  - B: sext({ir[31], ir[7], ir[30:25], ir[11:8], 0}).
  - U: sext({ir[31:12], 12'b0}).
  - J: sext({ir[31], ir[19:12], ir[20], ir[30:21], 0}).
- Decode is combinational on in_ir; the result is captured with the entry.
- Latency: an instruction accepted at edge N is visible on out_* immediately after edge N.
- Accept = in_valid AND in_ready:
  - If out register is empty or out_ready=1: the accepted entry loads the out register.
  - Otherwise: it loads the skid register.
- Consume = out_valid AND out_ready:
  - If skid is valid: skid moves to the out register, skid_valid clears, and in_ready rises next cycle.
- Skid full (in_ready=0): no accept even if a consume happens the same cycle. Order is preserved; no loss or duplication.
- out_* hold stable while out_valid=1 and out_ready=0.
- flush=1: both valids clear at the next edge. An input presented in the same cycle is discarded. in_ready=1 the following cycle. flush has priority over accept and consume.

Optional Feature:
Macro IMMGEN_RVC_EN.

With the macro defined, in_ir[1:0] != 11 is treated as a 16-bit instruction in in_ir[15:0], with out_rvc=1. All immediates are sign-extended except C.LW, C.SW, C.LWSP and C.SWSP, which are zero-extended. Supported forms (quadrant op, funct3):
- 01/000, 01/010 (C.ADDI, C.LI): {ir[12], ir[6:2]}, fmt I.
- 01/011 (C.LUI): {ir[12], ir[6:2], 12'b0}, fmt U.
- 01/001, 01/101 (C.JAL, C.J): offset[11|4|9:8|10|6|7|3:1|5] = ir[12|11|10:9|8|7|6|5:3|2], fmt J.
- 01/110, 01/111 (C.BEQZ, C.BNEZ): offset[8|4:3|7:6|2:1|5] = ir[12|11:10|6:5|4:3|2], fmt B.
- 00/010, 00/110 (C.LW, C.SW): uimm[5:3|2|6] = ir[12:10|6|5]; fmt I for C.LW, S for C.SW.
- 10/010 (C.LWSP): uimm[5|4:2|7:6] = ir[12|6:4|3:2], fmt I.
- 10/110 (C.SWSP): uimm[5:2|7:6] = ir[12:9|8:7], fmt S.
- Any other compressed form: fmt 7, imm 0.

Without the macro, every word is decoded as 32-bit and out_rvc=0.

Test Plan:
- Format decode: in_ir=0xFFF00093, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=0, out_tag matches input.
- Branch and jump: in_ir=0xFE000EE3 -> imm 0xFFFFFFFC, fmt 2; then 0x0080006F -> imm 0x00000008, fmt 4, in consecutive cycles.
- Back-pressure: out_ready=0, offer A, B, C back-to-back -> A in out register, B in skid, in_ready=0 and C held. Raise out_ready -> A, B, C emerge in order, one per cycle, none lost or duplicated.
- Flush and reset: both entries full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered word dropped. Repeat with rst pulsed low mid-cycle -> out_valid drops asynchronously.
- XLEN=64: in_ir=0x800002B7 -> out_imm=0xFFFFFFFF80000000, fmt 3.
- IMMGEN_RVC_EN: in_ir=0x000050FD -> imm 0xFFFFFFFF, fmt 0, out_rvc=1. Without the macro -> fmt 7, out_rvc=0.
